wm_cycle_sequencer: RTL and testbench

//  Program-level controller for the washing-machine datapath: door lock, fill valve, drain pump, motor.

---
 rtl/wm_cycle_sequencer_if.sv | 29 ++
 rtl/wm_cycle_sequencer.sv | 162 ++++++++++++++++
 tb/tb_wm_cycle_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wm_cycle_sequencer_if.sv
// Washing-machine sequencer bus: command/sensor inputs and actuator/status outputs.
interface wm_cycle_sequencer_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] prog;
  logic       door_closed;
  logic       level_full;
  logic       level_empty;
  logic       door_lock;
  logic       fill_valve;
  logic       drain_pump;
  logic [1:0] motor;
  logic [3:0] phase;
  logic       busy;
  logic       done;
  logic [1:0] fault_code;

  modport master (
    output tick, start, pause, abort, prog, door_closed, level_full, level_empty,
    input  door_lock, fill_valve, drain_pump, motor, phase, busy, done, fault_code
  );

  modport slave (
    input  tick, start, pause, abort, prog, door_closed, level_full, level_empty,
    output door_lock, fill_valve, drain_pump, motor, phase, busy, done, fault_code
  );
endinterface

// File: rtl/wm_cycle_sequencer.sv
// Program-level washing-machine controller: LOCK, FILL, WASH, DRAIN, N x (FILL,
// RINSE, DRAIN), SPIN, DONE, with pause/resume, abort-with-drain and fault lockout.
module wm_cycle_sequencer #(
  parameter int WASH_T    = 10,
  parameter int RINSE_T   = 5,
  parameter int SPIN_T    = 7,
  parameter int LOCK_T    = 2,
  parameter int FILL_TMO  = 12,
  parameter int DRAIN_TMO = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  wm_cycle_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOCK   = 4'd1,
    S_FILL   = 4'd2,
    S_WASH   = 4'd3,
    S_DRAIN  = 4'd4,
    S_RINSE  = 4'd5,
    S_SPIN   = 4'd6,
    S_DONE   = 4'd7,
    S_PAUSED = 4'd8,
    S_ABORT  = 4'd9,
    S_FAULT  = 4'd10
  } phase_t;

  phase_t     state, nxt, norm, ret;
  logic [7:0] timer;
  logic [7:0] wash_last;
  logic [1:0] rinse_left;
  logic [1:0] fcode, fcode_nxt;
  logic       heavy, first;
  logic       locked_now, tmo, take_norm;
  logic       do_latch, do_dec, do_wash;
  logic       resume, hold_timer;

  assign wash_last  = heavy ? 8'(2*WASH_T-1) : 8'(WASH_T-1);
  // Every phase that holds the door closed except FAULT, which ignores the door.
  assign locked_now = !(state inside {S_IDLE, S_DONE, S_FAULT});
  assign resume     = (state == S_PAUSED) && (nxt == ret);
  // Entering PAUSED freezes the timer; leaving it back to the saved phase keeps it.
  assign hold_timer = (nxt == S_PAUSED) || resume;

  // Next-phase logic: normal transition first, then override by priority.
  always_comb begin
    norm      = state;
    fcode_nxt = fcode;
    tmo       = 1'b0;
    do_latch  = 1'b0;
    do_dec    = 1'b0;
    do_wash   = 1'b0;
    case (state)
      S_IDLE:   if (bus.start && bus.door_closed) begin
                  norm     = S_LOCK;
                  do_latch = 1'b1;
                end
      S_LOCK:   if (bus.tick && timer == 8'(LOCK_T-1)) norm = S_FILL;
      S_FILL:   if (bus.level_full) begin
                  norm    = first ? S_WASH : S_RINSE;
                  do_wash = first;
                end else if (bus.tick && timer == 8'(FILL_TMO-1)) begin
                  tmo       = 1'b1;
                  fcode_nxt = 2'b01;
                end
      S_WASH:   if (bus.tick && timer == wash_last) norm = S_DRAIN;
      S_RINSE:  if (bus.tick && timer == 8'(RINSE_T-1)) begin
                  norm   = S_DRAIN;
                  do_dec = 1'b1;
                end
      S_DRAIN:  if (bus.level_empty) begin
                  norm = (rinse_left != 2'd0) ? S_FILL : S_SPIN;
                end else if (bus.tick && timer == 8'(DRAIN_TMO-1)) begin
                  tmo       = 1'b1;
                  fcode_nxt = 2'b10;
                end
      S_SPIN:   if (bus.tick && timer == 8'(SPIN_T-1)) norm = S_DONE;
      S_DONE:   norm = S_IDLE;
      S_PAUSED: if (bus.start) norm = ret;
      S_ABORT:  if (bus.level_empty) begin
                  norm = S_IDLE;
                end else if (bus.tick && timer == 8'(DRAIN_TMO-1)) begin
                  tmo       = 1'b1;
                  fcode_nxt = 2'b10;
                end
      default:  norm = state;
    endcase

    nxt       = norm;
    take_norm = 1'b1;
    if (locked_now && !bus.door_closed) begin
      nxt       = S_FAULT;
      fcode_nxt = 2'b11;
      take_norm = 1'b0;
    end else if (tmo) begin
      nxt       = S_FAULT;
      take_norm = 1'b0;
    end else if (bus.abort && locked_now && state != S_ABORT) begin
      nxt       = S_ABORT;
      take_norm = 1'b0;
    end else if (bus.pause && state inside {[S_LOCK:S_SPIN]}) begin
      nxt       = S_PAUSED;
      take_norm = 1'b0;
    end
  end

  // Phase, program, rinse count, return phase and phase timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ret        <= S_IDLE;
      timer      <= 8'd0;
      rinse_left <= 2'd0;
      heavy      <= 1'b0;
      first      <= 1'b0;
      fcode      <= 2'b00;
    end else begin
      state <= nxt;
      fcode <= fcode_nxt;
      if (nxt == S_PAUSED && state != S_PAUSED) ret <= state;
      if (take_norm && do_latch) begin
        heavy      <= (bus.prog == 2'b10);
        rinse_left <= (bus.prog == 2'b00) ? 2'd1 : (bus.prog == 2'b10) ? 2'd3 : 2'd2;
        first      <= 1'b1;
      end
      if (take_norm && do_wash) first <= 1'b0;
      if (take_norm && do_dec)  rinse_left <= rinse_left - 2'd1;
      if (nxt != state) begin
        if (!hold_timer) timer <= 8'd0;
      end else if (bus.tick && locked_now && state != S_PAUSED) begin
        timer <= timer + 8'd1;
      end
    end
  end

  // Moore outputs registered from the next phase so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.door_lock  <= 1'b0;
      bus.fill_valve <= 1'b0;
      bus.drain_pump <= 1'b0;
      bus.motor      <= 2'b00;
      bus.phase      <= 4'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.fault_code <= 2'b00;
    end else begin
      bus.door_lock  <= !(nxt inside {S_IDLE, S_DONE});
      bus.fill_valve <= (nxt == S_FILL);
      bus.drain_pump <= (nxt == S_DRAIN) || (nxt == S_ABORT);
      bus.motor      <= (nxt == S_WASH || nxt == S_RINSE) ? 2'b01 :
                        (nxt == S_SPIN) ? 2'b10 : 2'b00;
      bus.phase      <= nxt;
      bus.busy       <= !(nxt inside {S_IDLE, S_DONE, S_FAULT});
      bus.done       <= (nxt == S_DONE);
      bus.fault_code <= fcode_nxt;
    end
  end

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Directed bench for wm_cycle_sequencer: program table plus corner-case sequences.
module tb_wm_cycle_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wm_cycle_sequencer_if bus();
  wm_cycle_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [1:0] prog;
    int         wash;
    int         rinses;
  } vec_t;
  vec_t tbl[4];

  int  n_cmp = 0, n_bad = 0;
  int  fill_cnt = 0, drain_cnt = 0, dec_err = 0;
  bit  full_en = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Expected actuator/status decode for the observed phase.
  function automatic bit dec_ok();
    int p;
    bit lk, fv, dp, bs, dn;
    logic [1:0] mo;
    p  = int'(bus.phase);
    lk = (p >= 1 && p <= 6) || (p >= 8 && p <= 10);
    fv = (p == 2);
    dp = (p == 4) || (p == 9);
    mo = (p == 3 || p == 5) ? 2'b01 : (p == 6) ? 2'b10 : 2'b00;
    bs = (p >= 1 && p <= 6) || p == 8 || p == 9;
    dn = (p == 7);
    return bus.door_lock == lk && bus.fill_valve == fv && bus.drain_pump == dp &&
           bus.motor == mo && bus.busy == bs && bus.done == dn;
  endfunction

  // One clock; the drum model fills/empties 3 samples after valve/pump open.
  task automatic step();
    @(posedge clk);
    #1;
    fill_cnt        = bus.fill_valve ? fill_cnt + 1 : 0;
    drain_cnt       = bus.drain_pump ? drain_cnt + 1 : 0;
    bus.level_full  = full_en && fill_cnt >= 3;
    bus.level_empty = drain_cnt >= 3;
    if (!dec_ok()) dec_err++;
  endtask

  task automatic wait_phase(input string nm, input int p, input int max);
    for (int k = 0; k < max && int'(bus.phase) != p; k++) step();
    chk(nm, int'(bus.phase), p);
  endtask

  task automatic do_reset();
    bus.start = 0; bus.pause = 0; bus.abort = 0; bus.door_closed = 1;
    full_en = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int w, rt, rent, s, dn, lk, prev, cnt;
    bit fin;
    tbl[0] = '{2'b00, 10, 1};
    tbl[1] = '{2'b01, 10, 2};
    tbl[2] = '{2'b10, 20, 3};
    tbl[3] = '{2'b11, 10, 2};

    bus.tick = 1; bus.start = 0; bus.pause = 0; bus.abort = 0; bus.prog = 2'b00;
    bus.door_closed = 1; bus.level_full = 0; bus.level_empty = 0;
    do_reset();
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_outs", {bus.door_lock, bus.fill_valve, bus.drain_pump, bus.motor,
                     bus.busy, bus.done, bus.fault_code}, 0);

    // Start with door open is ignored.
    bus.door_closed = 0; bus.start = 1; step(); bus.start = 0; step();
    chk("door_open_start", int'(bus.phase), 0);
    chk("door_open_lock", bus.door_lock, 0);
    bus.door_closed = 1; step();

    // Full programs; prog is scrambled right after start and must not matter.
    for (int i = 0; i < 4; i++) begin
      dec_err = 0;
      bus.prog = tbl[i].prog; bus.start = 1; step(); bus.start = 0;
      bus.prog = ~tbl[i].prog;
      w = 0; rt = 0; rent = 0; s = 0; dn = 0; lk = 0; prev = 0; fin = 0;
      for (int k = 0; k < 400 && !fin; k++) begin
        case (int'(bus.phase))
          1: lk++;
          3: w++;
          5: rt++;
          6: s++;
          7: dn++;
          default: ;
        endcase
        if (int'(bus.phase) == 5 && prev != 5) rent++;
        prev = int'(bus.phase);
        if (int'(bus.phase) == 0) fin = 1; else step();
      end
      chk($sformatf("p%0d_finish", i), fin, 1);
      chk($sformatf("p%0d_lock", i), lk, 2);
      chk($sformatf("p%0d_wash", i), w, tbl[i].wash);
      chk($sformatf("p%0d_rinses", i), rent, tbl[i].rinses);
      chk($sformatf("p%0d_rinse_t", i), rt, tbl[i].rinses * 5);
      chk($sformatf("p%0d_spin", i), s, 7);
      chk($sformatf("p%0d_done", i), dn, 1);
      chk($sformatf("p%0d_unlock", i), bus.door_lock, 0);
      chk($sformatf("p%0d_decode", i), dec_err, 0);
      step();
    end

    // Pause at WASH tick 4, hold 6, resume for the remaining 6.
    do_reset();
    bus.prog = 2'b01; bus.start = 1; step(); bus.start = 0;
    wait_phase("pz_reach_wash", 3, 50);
    repeat (4) step();
    chk("pz_still_wash", int'(bus.phase), 3);
    bus.pause = 1; step(); bus.pause = 0;
    chk("pz_paused", int'(bus.phase), 8);
    chk("pz_motor", bus.motor, 0);
    chk("pz_lock", bus.door_lock, 1);
    repeat (5) step();
    chk("pz_hold", int'(bus.phase), 8);
    bus.start = 1; step(); bus.start = 0;
    chk("pz_resume", int'(bus.phase), 3);
    cnt = 0;
    for (int k = 0; k < 40 && int'(bus.phase) == 3; k++) begin cnt++; step(); end
    chk("pz_remaining", cnt, 6);
    chk("pz_then_drain", int'(bus.phase), 4);

    // Fill timeout.
    do_reset();
    full_en = 1'b0;
    bus.prog = 2'b01; bus.start = 1; step(); bus.start = 0;
    wait_phase("ft_reach_fill", 2, 20);
    cnt = 0;
    for (int k = 0; k < 40 && int'(bus.phase) == 2; k++) begin cnt++; step(); end
    chk("ft_fill_ticks", cnt, 12);
    chk("ft_phase", int'(bus.phase), 10);
    chk("ft_code", bus.fault_code, 1);
    chk("ft_lock", bus.door_lock, 1);
    chk("ft_valve", bus.fill_valve, 0);
    bus.start = 1; repeat (3) step(); bus.start = 0;
    chk("ft_sticky", int'(bus.phase), 10);
    do_reset();
    chk("ft_cleared", {bus.phase, bus.fault_code, bus.door_lock}, 0);

    // Door opened during SPIN.
    bus.prog = 2'b00; bus.start = 1; step(); bus.start = 0;
    wait_phase("do_reach_spin", 6, 200);
    bus.door_closed = 0; step();
    chk("do_phase", int'(bus.phase), 10);
    chk("do_code", bus.fault_code, 3);
    chk("do_motor", bus.motor, 0);
    do_reset();

    // Abort during RINSE drains then unlocks.
    bus.prog = 2'b01; bus.start = 1; step(); bus.start = 0;
    wait_phase("ab_reach_rinse", 5, 200);
    step();
    bus.abort = 1; step(); bus.abort = 0;
    chk("ab_phase", int'(bus.phase), 9);
    chk("ab_pump", bus.drain_pump, 1);
    chk("ab_motor", bus.motor, 0);
    wait_phase("ab_idle", 0, 20);
    chk("ab_unlock", bus.door_lock, 0);
    chk("ab_busy", bus.busy, 0);

    // Async reset between edges mid-SPIN.
    bus.prog = 2'b00; bus.start = 1; step(); bus.start = 0;
    wait_phase("ar_reach_spin", 6, 200);
    #2 rst = 1'b1;
    #1;
    chk("ar_outs", {bus.door_lock, bus.motor, bus.phase, bus.busy, bus.fault_code}, 0);
    step(); rst = 1'b0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
